// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control-token constants, token lookup and decoder state type
package tmds_pkg;

    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic       is_token;
        logic [1:0] ctrl;
    } token_info_t;

    function automatic token_info_t token_lookup(input logic [9:0] word);
        token_info_t info;
        info.is_token = 1'b1;
        info.ctrl     = 2'b00;
        case (word)
            TOKEN_00: info.ctrl = 2'b00;
            TOKEN_01: info.ctrl = 2'b01;
            TOKEN_10: info.ctrl = 2'b10;
            TOKEN_11: info.ctrl = 2'b11;
            default:  info.is_token = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/tmds_word_dec.sv
// rtl/tmds_word_dec.sv - combinational decode of one aligned 10-bit TMDS word
module tmds_word_dec
    import tmds_pkg::*;
(
    input  logic [9:0] word,
    output logic       is_token,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    token_info_t info;
    logic [7:0]  q;

    // Non-token words always decode arithmetically, even if they are not legal 8b/10b symbols.
    always_comb begin
        info     = token_lookup(word);
        is_token = info.is_token;
        ctrl     = info.ctrl;
        q        = word[9] ? ~word[7:0] : word[7:0];
        data     = 8'h00;
        data[0]  = q[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

endmodule

// File: rtl/tmds_dec.sv
// rtl/tmds_dec.sv - TMDS channel decoder with bit-slip word alignment and lock monitoring
module tmds_dec
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN      = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOSS_TIMEOUT  = 4096
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [9:0] tmds_word_i,
    output logic [7:0] data_o,
    output logic       de_o,
    output logic [1:0] ctrl_o,
    output logic       locked_o,
    output logic [3:0] offset_o
);

    localparam int RUN_W  = $clog2(CTRL_RUN) + 1;
    localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

    state_t            state, state_next;
    logic [9:0]        prev_word;
    logic [9:0]        stage1;
    logic [19:0]       window;
    logic [19:0]       shifted;
    logic [9:0]        aligned;
    logic [3:0]        offset, offset_next;
    logic [RUN_W-1:0]  run_cnt, run_next;
    logic [WIN_W-1:0]  win_cnt, win_next;
    logic [LOSS_W-1:0] loss_cnt, loss_next;

    logic              s1_tok;
    logic [1:0]        s1_ctrl;
    logic [7:0]        s1_data;
    logic              run_done;
    logic              win_done;
    logic              loss_done;

    // The older word occupies the low half, so offset k starts k bits into the previous word.
    assign window  = {tmds_word_i, prev_word};
    assign shifted = window >> offset;
    assign aligned = shifted[9:0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_word <= '0;
            stage1    <= '0;
        end else begin
            prev_word <= tmds_word_i;
            stage1    <= aligned;
        end
    end

    tmds_word_dec u_word_dec (
        .word     (stage1),
        .is_token (s1_tok),
        .ctrl     (s1_ctrl),
        .data     (s1_data)
    );

    assign run_done  = s1_tok && (run_cnt == RUN_W'(CTRL_RUN - 1));
    assign win_done  = (win_cnt == WIN_W'(SEARCH_WINDOW - 1));
    assign loss_done = !s1_tok && (loss_cnt == LOSS_W'(LOSS_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= SEARCH;
            offset   <= '0;
            run_cnt  <= '0;
            win_cnt  <= '0;
            loss_cnt <= '0;
        end else begin
            state    <= state_next;
            offset   <= offset_next;
            run_cnt  <= run_next;
            win_cnt  <= win_next;
            loss_cnt <= loss_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEARCH:  if (run_done)  state_next = LOCKED;
            LOCKED:  if (loss_done) state_next = SEARCH;
            default: state_next = SEARCH;
        endcase
    end

    // A run completing on the window's last cycle takes priority over the bit slide.
    always_comb begin
        offset_next = offset;
        run_next    = '0;
        win_next    = '0;
        loss_next   = '0;
        case (state)
            SEARCH: begin
                if (run_done) begin
                    run_next = '0;
                    win_next = '0;
                end else if (win_done) begin
                    offset_next = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                end else begin
                    run_next = s1_tok ? run_cnt + RUN_W'(1) : '0;
                    win_next = win_cnt + WIN_W'(1);
                end
            end
            LOCKED: begin
                if (s1_tok || loss_done) begin
                    loss_next = '0;
                end else begin
                    loss_next = loss_cnt + LOSS_W'(1);
                end
            end
            default: offset_next = offset;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o <= '0;
            de_o   <= 1'b0;
            ctrl_o <= '0;
        end else if (state == LOCKED) begin
            if (s1_tok) begin
                data_o <= '0;
                de_o   <= 1'b0;
                ctrl_o <= s1_ctrl;
            end else begin
                data_o <= s1_data;
                de_o   <= 1'b1;
            end
        end else begin
            data_o <= '0;
            de_o   <= 1'b0;
        end
    end

    assign locked_o = (state == LOCKED);
    assign offset_o = offset;

endmodule

// File: tb/tb_tmds_dec.sv
// tb/tb_tmds_dec.sv - randomized self-checking bench for tmds_dec against a behavioural model
module tb_tmds_dec;

    localparam int SW   = 16;
    localparam int LT   = 4096;
    localparam int RUN  = 8;
    localparam int BLNK = 'h354;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] tmds_word = '0;
    logic [7:0] data_o;
    logic       de_o;
    logic [1:0] ctrl_o;
    logic       locked_o;
    logic [3:0] offset_o;

    int n_cmp = 0;
    int n_err = 0;

    int m_prev, m_s1, m_off, m_run, m_win, m_loss, m_data, m_ctrl;
    bit m_locked, m_de;
    int sh_prev;

    tmds_dec #(.SEARCH_WINDOW(SW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .tmds_word_i (tmds_word),
        .data_o      (data_o),
        .de_o        (de_o),
        .ctrl_o      (ctrl_o),
        .locked_o    (locked_o),
        .offset_o    (offset_o)
    );

    always #5 clk = ~clk;

    function automatic int tok_val(int w);
        case (w)
            'h354:   return 0;
            'h0AB:   return 1;
            'h154:   return 2;
            'h2AB:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int dec_val(int w);
        int q, d, b;
        q = ((w >> 9) & 1) ? (~w & 255) : (w & 255);
        d = q & 1;
        for (int i = 1; i < 8; i++) begin
            b = ((q >> i) & 1) ^ ((q >> (i - 1)) & 1);
            if (((w >> 8) & 1) == 0) b = 1 - b;
            d = d | (b << i);
        end
        return d;
    endfunction

    function automatic int rand_data();
        int w;
        w = int'($urandom_range(0, 1023));
        if (tok_val(w) >= 0) w = w ^ 1;
        return w;
    endfunction

    function automatic logic [15:0] dut_vec();
        return {data_o, de_o, ctrl_o, locked_o, offset_o};
    endfunction

    function automatic logic [15:0] model_vec();
        return {8'(m_data), m_de, 2'(m_ctrl), m_locked, 4'(m_off)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_s1 = 0; m_off = 0; m_run = 0; m_win = 0; m_loss = 0;
        m_data = 0; m_ctrl = 0; m_locked = 0; m_de = 0;
    endtask

    task automatic model_step(input int w);
        int aligned, t;
        aligned = (((w << 10) | m_prev) >> m_off) & 1023;
        t = tok_val(m_s1);
        if (m_locked && t >= 0) begin
            m_de = 0; m_data = 0; m_ctrl = t;
        end else if (m_locked) begin
            m_de = 1; m_data = dec_val(m_s1);
        end else begin
            m_de = 0; m_data = 0;
        end
        if (!m_locked) begin
            if (t >= 0 && m_run + 1 == RUN) begin
                m_locked = 1; m_run = 0; m_win = 0;
            end else if (m_win + 1 == SW) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_win = 0;
            end else begin
                m_run = (t >= 0) ? m_run + 1 : 0;
                m_win = m_win + 1;
            end
        end else begin
            if (t >= 0) m_loss = 0;
            else if (m_loss + 1 == LT) begin
                m_locked = 0; m_loss = 0;
            end else m_loss = m_loss + 1;
        end
        m_s1 = aligned;
        m_prev = w;
    endtask

    // Every clock is checked against the model right after the edge.
    task automatic tick(input int w);
        tmds_word = 10'(w);
        if (rst_n) model_step(w & 1023);
        else model_reset();
        @(posedge clk);
        #1;
        check("cycle", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(0);
        rst_n = 1'b1;
    endtask

    // Serial stream of 10-bit symbols cut into words s bits late.
    task automatic send_sym(input int sym, input int s);
        int w;
        w = (((sym << 10) | sh_prev) >> (10 - s)) & 1023;
        sh_prev = sym;
        tick(w);
    endtask

    initial begin
        int drop, found, saw9, s, len;
        model_reset();
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            tick(int'($urandom_range(0, 1023)));
            check("reset_outputs", dut_vec(), 16'h0000);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) tick(rand_data());
        check("no_lock_on_data", {15'b0, locked_o}, 16'h0000);

        do_reset();
        for (int i = 0; i < 8; i++) tick(BLNK);
        tick('h1FF);
        check("pre_lock", {15'b0, locked_o}, 16'h0000);
        tick('h300);
        check("lock_after_8th", {13'b0, locked_o, ctrl_o}, 16'h0004);
        tick('h154);
        check("data_1ff", {7'b0, data_o, de_o}, {7'b0, 8'h01, 1'b1});
        tick(BLNK);
        check("data_inverted", {7'b0, data_o, de_o}, {7'b0, 8'h01, 1'b1});
        tick(BLNK);
        check("ctrl_10", {5'b0, data_o, de_o, ctrl_o}, 16'h0002);
        tick(BLNK);
        check("ctrl_00", {13'b0, de_o, ctrl_o}, 16'h0000);

        for (int i = 0; i < 3; i++) tick(BLNK);
        drop = 0;
        for (int i = 1; i <= 4200 && drop == 0; i++) begin
            tick('h1FF);
            if (!locked_o) drop = i;
        end
        check("loss_edge", 16'(drop), 16'(4098));
        check("loss_offset_kept", {12'b0, offset_o}, 16'h0000);

        do_reset();
        for (int i = 0; i < 10; i++) tick(BLNK);
        for (int i = 0; i < 3; i++) tick('h1FF);
        check("pre_reset_active", {14'b0, locked_o, de_o}, 16'h0003);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_vec(), 16'h0000);
        tick(0);
        rst_n = 1'b1;

        do_reset();
        sh_prev = BLNK;
        for (int i = 1; i <= 60; i++) begin
            send_sym(BLNK, 3);
            if (i == 16) check("slide_1", {12'b0, offset_o}, 16'h0001);
            if (i == 32) check("slide_2", {12'b0, offset_o}, 16'h0002);
            if (i == 48) check("slide_3", {12'b0, offset_o}, 16'h0003);
            if (i == 56) check("no_early_lock", {15'b0, locked_o}, 16'h0000);
            if (i == 57) check("misalign_lock", {11'b0, locked_o, offset_o}, 16'h0013);
        end
        send_sym('h1FF, 3);
        found = 0;
        for (int i = 0; i < 6; i++) begin
            send_sym(BLNK, 3);
            if (de_o && data_o == 8'h01) found = 1;
        end
        check("misalign_data", 16'(found), 16'h0001);

        do_reset();
        sh_prev = BLNK;
        for (int i = 0; i < 300 && !locked_o; i++) send_sym(BLNK, 1);
        check("lock_at_1", {11'b0, locked_o, offset_o}, 16'h0011);
        for (int i = 0; i < 4200 && locked_o; i++) tick('h1FF);
        check("loss_keeps_1", {11'b0, locked_o, offset_o}, 16'h0001);
        sh_prev = BLNK;
        saw9 = 0;
        for (int i = 0; i < 400 && !locked_o; i++) begin
            send_sym(BLNK, 0);
            if (offset_o == 4'd9) saw9 = 1;
        end
        check("wrap_saw_9", 16'(saw9), 16'h0001);
        check("wrap_lock_0", {11'b0, locked_o, offset_o}, 16'h0010);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            s = int'($urandom_range(0, 9));
            sh_prev = BLNK;
            for (int b = 0; b < 12; b++) begin
                len = int'($urandom_range(10, 24));
                for (int i = 0; i < len; i++) send_sym(BLNK, s);
                len = int'($urandom_range(1, 6));
                for (int i = 0; i < len; i++) send_sym('h0AB + 'h200 * int'($urandom_range(0, 1)), s);
                len = int'($urandom_range(5, 40));
                for (int i = 0; i < len; i++) send_sym(rand_data(), s);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
